// File: rtl/gate_unit_pipe.sv
// gate_unit_pipe: registered bitwise gate unit with a DEPTH-entry result FIFO.
// One of eight bitwise ops (AND, OR, NOT a, XOR, NAND, NOR, XNOR, BUF a) is
// applied to a/b on accept and the result is queued for a possibly stalling
// consumer.
// Optional feature macro: GATE_STATS_EN adds the op_count port, a wrapping
// count of accepted transactions.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready depends only on registered occupancy, so it never looks at
// out_ready. When the FIFO is full, no push is taken that cycle, even if a pop
// frees a slot in the same cycle. out_valid stays high until a pop, and y is
// stable while out_valid && !out_ready. y reads as 0 whenever the FIFO is
// empty.
module gate_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef GATE_STATS_EN
  ,
  output logic [CNT_W-1:0] op_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic [WIDTH-1:0] result;
  logic             full, empty, push, pop;

  assign full      = (occ_q == OCC_FULL);
  assign empty     = (occ_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign y         = empty ? '0 : mem_q[rd_ptr_q];

  // Bitwise gate selected by op; b is unused by NOT and BUF.
  always_comb begin
    result = a;
    case (op)
      3'b000:  result = a & b;
      3'b001:  result = a | b;
      3'b010:  result = ~a;
      3'b011:  result = a ^ b;
      3'b100:  result = ~(a & b);
      3'b101:  result = ~(a | b);
      3'b110:  result = ~(a ^ b);
      default: result = a;
    endcase
  end

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  // FIFO control registers; reset discards everything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Result storage, written at the tail on every accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= result;
    end
  end

`ifdef GATE_STATS_EN
  logic [CNT_W-1:0] op_count_q;

  // Accepted-transaction counter; wraps at 2^CNT_W and ignores pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= '0;
    else if (push) op_count_q <= op_count_q + 1'b1;
  end

  assign op_count = op_count_q;
`endif

endmodule
